// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side bus of uart_tx_arbiter: per-requester byte streams in,
// one shared UART TX write port out, plus FSM debug visibility.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a byte moves on requester i in any cycle where req_valid[i]
    // and req_ready[i] are both high; valid/data/last must stay stable until then.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic                      wr_uart;
    logic [DATA_W-1:0]         w_data;
    logic                      tx_full;
    logic                      timeout_pulse;
    logic                      dbg_state;
    logic [IDX_W-1:0]          dbg_rr_ptr;

    modport master (
        output req_valid, req_last, req_data, tx_full,
        input  req_ready, grant, busy, wr_uart, w_data, timeout_pulse,
        input  dbg_state, dbg_rr_ptr
    );

    modport slave (
        input  req_valid, req_last, req_data, tx_full,
        output req_ready, grant, busy, wr_uart, w_data, timeout_pulse,
        output dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX write port among NUM_REQ message streams.
// Optional idle-owner grant revocation is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   rr_off, rr_sel, owner_inc;
    logic [IDX_W:0]     rr_sum;
    logic [NUM_REQ-1:0] rot_valid;
    logic               own_valid, own_last, xfer, expire;
    logic [DATA_W-1:0]  own_data;
    logic [NUM_REQ-1:0] ready_c, grant_c;
    logic [DATA_W-1:0]  w_data_c;

    always_comb begin
        own_valid = bus.req_valid[owner_q];
        own_last  = bus.req_last[owner_q];
        own_data  = bus.req_data[owner_q*DATA_W +: DATA_W];
        xfer      = (state_q == OWN) && own_valid && !bus.tx_full;
        owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the nearest requester.
    always_comb begin
        rot_valid = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
        rr_off    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) rr_off = IDX_W'(i);
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
        if (int'(rr_sum) >= NUM_REQ) rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
        rr_sel = rr_sum[IDX_W-1:0];
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             timeout_pulse_q, timeout_pulse_d;

    // Revoke on the starved cycle that would bring the count to TIMEOUT-1.
    always_comb begin
        expire          = (state_q == OWN) && !own_valid &&
                          (idle_cnt_q == CNT_W'(TIMEOUT - 2));
        timeout_pulse_d = expire;
        idle_cnt_d      = idle_cnt_q;
        if (state_q == IDLE || xfer || expire) begin
            idle_cnt_d = '0;
        end else if (!own_valid) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q      <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            idle_cnt_q      <= idle_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign bus.timeout_pulse = timeout_pulse_q;
`else
    assign expire            = 1'b0;
    assign bus.timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    owner_d = rr_sel;
                    state_d = OWN;
                end
            end
            OWN: begin
                if ((xfer && own_last) || expire) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // grant/busy decode straight from flops, so they drop with async reset.
    always_comb begin
        ready_c  = '0;
        grant_c  = '0;
        w_data_c = xfer ? own_data : '0;
        if (state_q == OWN) begin
            ready_c[owner_q] = !bus.tx_full;
            grant_c[owner_q] = 1'b1;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.grant      = grant_c;
    assign bus.busy       = (state_q == OWN);
    assign bus.wr_uart    = xfer;
    assign bus.w_data     = w_data_c;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural requesters feed byte queues, a
// scoreboard of {last, owner, byte} entries checks every UART write in order.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;

    logic clk;
    logic reset;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(8)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_W(8), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0]  src_q [NREQ][$];
    logic [12:0] exp_q[$];
    int          stall_at [NREQ];
    int          sent_cnt [NREQ];
    bit          rand_mode;
    bit          gap_pending;
    int          wr_cnt;
    int          n_chk;
    int          n_err;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, req, $time);
        end
    endtask

    // ---------------- requester driver ----------------
    initial begin
        logic [NREQ-1:0] fire;
        logic [8:0]      head;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) sent_cnt[i] = 0;
        forever begin
            @(negedge clk);
            fire = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    sent_cnt[i]++;
                end
                if (rand_mode) begin
                    bus.req_valid[i]         = 1'($urandom_range(0, 1));
                    bus.req_last[i]          = 1'($urandom_range(0, 1));
                    bus.req_data[i*8 +: 8]   = 8'($urandom_range(0, 255));
                end else if (src_q[i].size() > 0 && sent_cnt[i] != stall_at[i]) begin
                    head                     = src_q[i][0];
                    bus.req_valid[i]         = 1'b1;
                    bus.req_last[i]          = head[8];
                    bus.req_data[i*8 +: 8]   = head[7:0];
                end else begin
                    bus.req_valid[i]         = 1'b0;
                    bus.req_last[i]          = 1'b0;
                    bus.req_data[i*8 +: 8]   = 8'h00;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic [12:0] e;
        logic [3:0]  own_obs;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("ready_iso", 32'(bus.req_ready & ~bus.grant), 32'h0);
                if (bus.tx_full) check("full_nowr", 32'(bus.wr_uart), 32'h0);
                if (!bus.wr_uart) check("wdata_zero", 32'(bus.w_data), 32'h0);
                if (gap_pending) begin
                    check("gap_idle", 32'(bus.busy), 32'h0);
                    gap_pending = 1'b0;
                end
                if (bus.wr_uart) begin
                    wr_cnt++;
                    own_obs = 4'hF;
                    for (int i = 0; i < NREQ; i++) if (bus.grant[i]) own_obs = 4'(i);
                    if (exp_q.size() == 0) begin
                        check("unexp_wr", 32'(exp_q.size()), 32'h1);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_byte", {20'h0, own_obs, bus.w_data}, {20'h0, e[11:0]});
                        if (e[12]) gap_pending = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic src_msg(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) src_q[r].push_back({(k == n - 1), 8'(base + k)});
    endtask

    task automatic exp_msg(input int r, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), 4'(r), 8'(base + k)});
    endtask

    function automatic bit all_src_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && all_src_empty() && !bus.busy &&
                               bus.req_valid == '0)) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'(exp_q.size()) + 32'h1000, 32'h0);
        @(negedge clk); #1;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (n < budget && wr_cnt < target) begin
            @(negedge clk); #1;
            n++;
        end
        if (wr_cnt < target) check("wr_timeout", 32'(wr_cnt), 32'(target));
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] g, input int budget);
        int n = 0;
        while (n < budget && bus.grant != g) begin
            @(negedge clk); #1;
            n++;
        end
        if (bus.grant != g) check("grant_timeout", 32'(bus.grant), 32'(g));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w0;
        int n;
        n_chk = 0; n_err = 0; wr_cnt = 0; gap_pending = 1'b0;
        for (int i = 0; i < NREQ; i++) stall_at[i] = -1;
        rand_mode   = 1'b1;
        reset       = 1'b0;
        bus.tx_full = 1'b0;

        // Reset holds every output low whatever the inputs do.
        repeat (4) begin
            @(posedge clk); #2;
            bus.tx_full = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            check("rst_outs", {bus.grant, bus.req_ready, 8'(bus.w_data), 2'(bus.busy),
                               2'(bus.wr_uart), 2'(bus.timeout_pulse)}, 32'h0);
        end
        @(negedge clk);
        rand_mode   = 1'b0;
        bus.tx_full = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("idle_grant", 32'(bus.grant), 32'h0);
        end
        check("idle_rr", 32'(bus.dbg_rr_ptr), 32'h0);

        // Round robin: 0 and 2 together, 0 wins, one idle cycle, then 2.
        src_msg(0, 3, 8'h41); src_msg(2, 3, 8'h41);
        exp_msg(0, 3, 8'h41); exp_msg(2, 3, 8'h41);
        w0 = wr_cnt;
        n = 0;
        while (n < 20 && bus.req_valid == '0) begin @(negedge clk); #1; n++; end
        check("lat_pre_grant", 32'(bus.grant), 32'h0);
        @(negedge clk); #1;
        check("lat_grant", 32'(bus.grant), 32'h1);
        check("lat_busy", 32'(bus.busy), 32'h1);
        check("lat_wr", 32'(bus.wr_uart), 32'h1);
        wait_wr(w0 + 3, 50);
        @(negedge clk); #1;
        check("rr_gap", 32'(bus.busy), 32'h0);
        @(negedge clk); #1;
        check("rr_second", 32'(bus.grant), 32'h4);
        wait_drain(100);

        // All four request: order continues from rr_ptr=3.
        src_msg(0, 2, 8'h10); src_msg(1, 2, 8'h20); src_msg(2, 2, 8'h30); src_msg(3, 2, 8'h40);
        exp_msg(3, 2, 8'h40); exp_msg(0, 2, 8'h10); exp_msg(1, 2, 8'h20); exp_msg(2, 2, 8'h30);
        wait_drain(200);

        // Back-pressure: 5 full cycles in the middle of a 6-byte message.
        src_msg(1, 6, 8'h60); exp_msg(1, 6, 8'h60);
        w0 = wr_cnt;
        wait_wr(w0 + 2, 50);
        @(posedge clk); #2;
        bus.tx_full = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            check("bp_wr", 32'(bus.wr_uart), 32'h0);
            check("bp_ready", 32'(bus.req_ready), 32'h0);
            check("bp_grant", 32'(bus.grant), 32'h2);
        end
        @(posedge clk); #2;
        bus.tx_full = 1'b0;
        @(negedge clk); #1;
        check("bp_resume", 32'(bus.wr_uart), 32'h1);
        wait_drain(100);

        // Single byte from 3, pointer wraps to 0.
        src_msg(3, 1, 8'h7E); exp_msg(3, 1, 8'h7E);
        wait_drain(50);
        check("wrap_rr", 32'(bus.dbg_rr_ptr), 32'h0);
        src_msg(2, 1, 8'h52); src_msg(1, 1, 8'h51); src_msg(0, 1, 8'h50);
        exp_msg(0, 1, 8'h50); exp_msg(1, 1, 8'h51); exp_msg(2, 1, 8'h52);
        wait_drain(100);

        // Owner isolation: 2 asks while 1 owns.
        src_msg(1, 4, 8'h90); exp_msg(1, 4, 8'h90);
        wait_grant(4'b0010, 50);
        src_msg(2, 2, 8'hA0); exp_msg(2, 2, 8'hA0);
        @(negedge clk); #1;
        check("iso_valid", 32'(bus.req_valid[2]), 32'h1);
        check("iso_ready", 32'(bus.req_ready[2]), 32'h0);
        check("iso_grant", 32'(bus.grant), 32'h2);
        wait_drain(100);

        // Owner goes quiet after one byte.
        stall_at[0] = sent_cnt[0] + 1;
        src_msg(0, 3, 8'hB0);
        w0 = wr_cnt;
`ifdef UART_ARB_TIMEOUT_EN
        src_msg(1, 2, 8'hC0);
        exp_q.push_back({1'b0, 4'd0, 8'hB0});
        exp_msg(1, 2, 8'hC0);
        wait_wr(w0 + 1, 50);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); #1;
            check("to_quiet", 32'(bus.timeout_pulse), 32'h0);
            check("to_busy", 32'(bus.busy), 32'h1);
        end
        @(negedge clk); #1;
        check("to_pulse", 32'(bus.timeout_pulse), 32'h1);
        check("to_idle", 32'(bus.busy), 32'h0);
        @(negedge clk); #1;
        check("to_next", 32'(bus.grant), 32'h2);
        check("to_one_shot", 32'(bus.timeout_pulse), 32'h0);
        src_q[0].delete();
        stall_at[0] = -1;
        wait_drain(100);
`else
        exp_msg(0, 3, 8'hB0);
        wait_wr(w0 + 1, 50);
        repeat (100) @(negedge clk);
        #1;
        check("hold_grant", 32'(bus.grant), 32'h1);
        check("hold_busy", 32'(bus.busy), 32'h1);
        check("hold_no_pulse", 32'(bus.timeout_pulse), 32'h0);
        stall_at[0] = -1;
        wait_drain(100);
`endif

        // Reset in the middle of a message.
        src_msg(2, 4, 8'hD0); exp_msg(2, 4, 8'hD0);
        w0 = wr_cnt;
        wait_wr(w0 + 1, 50);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_grant", 32'(bus.grant), 32'h0);
        check("mid_rst_wr", 32'(bus.wr_uart), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        exp_q.delete();
        src_q[2].delete();
        gap_pending = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk); #1;
        check("post_rst_grant", 32'(bus.grant), 32'h0);
        check("post_rst_rr", 32'(bus.dbg_rr_ptr), 32'h0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
